// File: rtl/dbi_pkg.sv
// Shared definitions for the DBI encoder.
//   DBI_MODE_AC / DBI_MODE_DC : values of the dbi_mode input
//   popcount(v, w)            : number of set bits in v[w-1:0]. Operands are
//                               zero-extended to POP_MAX bits, so callers
//                               cast their vector with POP_MAX'(x).
package dbi_pkg;

  localparam logic DBI_MODE_AC = 1'b0;  // minimise transitions
  localparam logic DBI_MODE_DC = 1'b1;  // minimise zeros

  // Widest vector popcount accepts. This bounds LANE_W and LANES.
  localparam int unsigned POP_MAX = 64;

  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v,
                                           input int unsigned         w);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < POP_MAX; i++)
      if (i < w) c += 32'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/dbi_lane_decide.sv
// Combinational DBI decision for one lane.
//   d         : raw lane data for this beat
//   prev_data : last encoded value driven on this lane's wires
//   prev_dbi  : last DBI flag driven for this lane
//   mode      : DBI_MODE_AC or DBI_MODE_DC
//   en        : 0 forces pass-through
//   inv       : 1 = send the lane inverted
//   enc       : d, or d inverted when inv is set
module dbi_lane_decide
  import dbi_pkg::*;
#(
  parameter int unsigned LANE_W = 8
) (
  input  logic [LANE_W-1:0] d,
  input  logic [LANE_W-1:0] prev_data,
  input  logic              prev_dbi,
  input  logic              mode,
  input  logic              en,
  output logic              inv,
  output logic [LANE_W-1:0] enc
);

  int unsigned t, ones, cost_keep, cost_inv;
  logic        ac_inv, dc_inv;

  always_comb begin
    t         = popcount(POP_MAX'(d ^ prev_data), LANE_W);
    ones      = popcount(POP_MAX'(d), LANE_W);
    // The DBI wire counts as a switching line, so its own toggle is part
    // of the cost. On a tie, keep the data uninverted.
    cost_keep = t + 32'(prev_dbi);
    cost_inv  = (LANE_W - t) + 32'(!prev_dbi);
    ac_inv    = cost_inv < cost_keep;
    // Zeros strictly above half. Exactly half means no inversion.
    dc_inv    = (LANE_W - ones) > (LANE_W / 2);
    inv       = en && ((mode == DBI_MODE_DC) ? dc_inv : ac_inv);
    enc       = d ^ {LANE_W{inv}};
  end

endmodule

// File: rtl/dbi_encoder.sv
// Multi-lane Data Bus Inversion encoder with a registered valid/ready
// output stage and a saturating inversion counter.
//   clk, rst            : clock, async active-high reset
//   dbi_en, dbi_mode    : enable and AC/DC select, sampled per accepted beat
//   in_valid/in_ready   : input handshake; in_data lane k = [k*LANE_W +: LANE_W]
//   out_valid/out_ready : output handshake
//   out_data, out_dbi   : encoded lanes and per-lane inversion flags
//   inv_count           : saturating total of inverted lanes since reset
module dbi_encoder
  import dbi_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dbi_en,
  input  logic                    dbi_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic [LANES-1:0]        out_dbi,
  output logic [CNT_W-1:0]        inv_count
);

  // Sum width: counter plus the largest per-beat increment, plus a guard bit.
  localparam int unsigned SW = CNT_W + $clog2(LANES + 1) + 1;

  logic [LANES-1:0][LANE_W-1:0] d_lane, enc_lane, wire_q;
  logic [LANES-1:0]             inv, dbi_q;
  logic [SW-1:0]                cnt_sum;
  logic [CNT_W-1:0]             cnt_next;
  logic                         acc;

  assign d_lane    = in_data;
  assign in_ready  = !out_valid || out_ready;
  assign acc       = in_valid && in_ready;
  assign out_data  = wire_q;
  assign out_dbi   = dbi_q;

  // The output register doubles as the lane history. Both are loaded with
  // the same values on every accept, and a drain does not clear data.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    dbi_lane_decide #(.LANE_W(LANE_W)) u_dec (
      .d         (d_lane[k]),
      .prev_data (wire_q[k]),
      .prev_dbi  (dbi_q[k]),
      .mode      (dbi_mode),
      .en        (dbi_en),
      .inv       (inv[k]),
      .enc       (enc_lane[k])
    );
  end

  always_comb begin
    cnt_sum  = SW'(inv_count) + SW'(popcount(POP_MAX'(inv), LANES));
    cnt_next = (cnt_sum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      wire_q    <= '0;
      dbi_q     <= '0;
      inv_count <= '0;
    end else begin
      if (in_ready) out_valid <= in_valid;
      if (acc) begin
        wire_q    <= enc_lane;
        dbi_q     <= inv;
        inv_count <= cnt_next;
      end
    end
  end

endmodule
